// File: rtl/jtag_tap_multi.sv
// jtag_tap_multi: IEEE 1149.1 TAP controller with IDCODE, BYPASS and NumUserDr external user DR channels
// Ports: tck_i/trst_ni/tms_i/td_i JTAG pins in; td_o/tdo_oe_o registered on tck falling edge;
//        tck_o/tdi_o feed-through; capture_o/shift_o/update_o/tlr_o state decodes;
//        user_select_o/user_tdo_i user DR channels; ir_o latched instruction; state_o TAP state.
module jtag_tap_multi #(
  parameter int unsigned IrLength       = 5,
  parameter logic [31:0] IdcodeValue    = 32'h00000001,
  parameter int unsigned NumUserDr      = 2,
  parameter int unsigned UserIrBase     = 'h10,
  parameter int unsigned IrCaptureValue = 'b00101
) (
  input  logic                 tck_i,
  input  logic                 trst_ni,
  input  logic                 tms_i,
  input  logic                 td_i,
  output logic                 td_o,
  output logic                 tdo_oe_o,
  output logic                 tck_o,
  output logic                 tdi_o,
  output logic                 capture_o,
  output logic                 shift_o,
  output logic                 update_o,
  output logic [NumUserDr-1:0] user_select_o,
  input  logic [NumUserDr-1:0] user_tdo_i,
  output logic                 tlr_o,
  output logic [IrLength-1:0]  ir_o,
  output logic [3:0]           state_o
);
  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, SEL_IR, CAP_DR, CAP_IR, SH_DR, SH_IR,
    EX1_DR, EX1_IR, PAU_DR, PAU_IR, UPD_DR, UPD_IR, EX2_DR, EX2_IR
  } state_e;
  localparam logic [IrLength-1:0] IrIdcode = IrLength'(1);
  state_e state_q, state_d;
  logic [IrLength-1:0] ir_q, ir_sr_q;
  logic [31:0] idcode_q;
  logic bypass_q, is_idcode, tdo_d;
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) state_q <= TLR;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:           state_d = tms_i ? TLR : RTI;
      RTI:           state_d = tms_i ? SEL_DR : RTI;
      SEL_DR:        state_d = tms_i ? SEL_IR : CAP_DR;
      SEL_IR:        state_d = tms_i ? TLR : CAP_IR;
      CAP_DR, SH_DR: state_d = tms_i ? EX1_DR : SH_DR;
      CAP_IR, SH_IR: state_d = tms_i ? EX1_IR : SH_IR;
      EX1_DR:        state_d = tms_i ? UPD_DR : PAU_DR;
      EX1_IR:        state_d = tms_i ? UPD_IR : PAU_IR;
      PAU_DR:        state_d = tms_i ? EX2_DR : PAU_DR;
      PAU_IR:        state_d = tms_i ? EX2_IR : PAU_IR;
      UPD_DR, UPD_IR: state_d = tms_i ? SEL_DR : RTI;
      EX2_DR:        state_d = tms_i ? UPD_DR : SH_DR;
      EX2_IR:        state_d = tms_i ? UPD_IR : SH_IR;
      default:       state_d = TLR;
    endcase
  end
  // IDCODE is also loaded on the edge that enters TLR, so ir_o already reads IDCODE once TLR is reached
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      ir_q    <= IrIdcode;
      ir_sr_q <= '0;
    end else begin
      if (state_q == CAP_IR) ir_sr_q <= IrLength'(IrCaptureValue);
      else if (state_q == SH_IR) ir_sr_q <= {td_i, ir_sr_q[IrLength-1:1]};
      if (state_q == TLR || state_d == TLR) ir_q <= IrIdcode;
      else if (state_q == UPD_IR) ir_q <= ir_sr_q;
    end
  end
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      idcode_q <= IdcodeValue;
      bypass_q <= 1'b0;
    end else if (state_q == CAP_DR) begin
      idcode_q <= IdcodeValue;
      bypass_q <= 1'b0;
    end else if (state_q == SH_DR) begin
      idcode_q <= {td_i, idcode_q[31:1]};
      bypass_q <= td_i;
    end
  end
  for (genvar k = 0; k < NumUserDr; k++) begin : g_sel
    assign user_select_o[k] = ir_q == IrLength'(UserIrBase + k);
  end
  assign is_idcode = ir_q == IrIdcode;
  assign tdo_d = state_q == SH_IR ? ir_sr_q[0] :
                 is_idcode ? idcode_q[0] :
                 |user_select_o ? |(user_select_o & user_tdo_i) : bypass_q;
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      td_o     <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      td_o     <= tdo_d;
      tdo_oe_o <= state_q == SH_IR || state_q == SH_DR;
    end
  end
  assign tck_o     = tck_i;
  assign tdi_o     = td_i;
  assign capture_o = state_q == CAP_DR;
  assign shift_o   = state_q == SH_DR;
  assign update_o  = state_q == UPD_DR;
  assign tlr_o     = state_q == TLR;
  assign ir_o      = ir_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_jtag_tap_multi.sv
// tb_jtag_tap_multi: randomized and directed checks of jtag_tap_multi against a behavioural TAP model
module tb_jtag_tap_multi;
  localparam logic [31:0] Idc = 32'h00000001;
  localparam logic [4:0] IrCap = 5'b00101;
  logic tck = 0, trst_ni = 0, tms_i = 0, td_i = 0;
  logic td_o, tdo_oe_o, tck_o, tdi_o, capture_o, shift_o, update_o, tlr_o;
  logic [1:0] user_select_o, user_tdo_i = '0;
  logic [4:0] ir_o;
  logic [3:0] state_o;
  int errors = 0, checks = 0;
  int ms;
  logic [4:0] mir, mirs;
  logic [31:0] midc;
  logic mbyp;
  int nxt0 [16] = '{1, 1, 4, 5, 6, 7, 6, 7, 10, 11, 10, 11, 1, 1, 6, 7};
  int nxt1 [16] = '{0, 2, 3, 0, 8, 9, 8, 9, 12, 13, 14, 15, 2, 2, 12, 13};

  jtag_tap_multi dut (
    .tck_i(tck), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i),
    .td_o(td_o), .tdo_oe_o(tdo_oe_o), .tck_o(tck_o), .tdi_o(tdi_o),
    .capture_o(capture_o), .shift_o(shift_o), .update_o(update_o),
    .user_select_o(user_select_o), .user_tdo_i(user_tdo_i),
    .tlr_o(tlr_o), .ir_o(ir_o), .state_o(state_o)
  );

  always #5 tck = ~tck;

  function automatic logic [1:0] exp_sel(input logic [4:0] ir);
    return (ir >= 5'h10 && ir < 5'h12) ? 2'(1 << (ir - 5'h10)) : 2'b00;
  endfunction

  task automatic model_reset();
    ms = 0; mir = 5'h1; mirs = '0; midc = Idc; mbyp = 1'b0;
  endtask

  task automatic step(input logic tms, input logic tdi, output logic seen);
    int ns;
    logic [1:0] sel;
    tms_i = tms; td_i = tdi; user_tdo_i = 2'($urandom);
    @(posedge tck);
    ns = tms ? nxt1[ms] : nxt0[ms];
    if (ms == 5) mirs = IrCap;
    else if (ms == 7) mirs = (mirs >> 1) | (5'(tdi) << 4);
    if (ms == 0 || ns == 0) mir = 5'h1;
    else if (ms == 13) mir = mirs;
    if (ms == 4) begin midc = Idc; mbyp = 1'b0; end
    else if (ms == 6) begin midc = (midc >> 1) | (32'(tdi) << 31); mbyp = tdi; end
    ms = ns;
    sel = exp_sel(mir);
    #1;
    checks++;
    if ({state_o, capture_o, shift_o, update_o, tlr_o} !== {ms[3:0], ms == 4, ms == 6, ms == 12, ms == 0}) begin
      errors++;
      $display("FAIL state: got state=%0d cap/sh/upd/tlr=%b%b%b%b want state=%0d", state_o, capture_o, shift_o, update_o, tlr_o, ms);
    end
    checks++;
    if ({ir_o, user_select_o} !== {mir, sel}) begin
      errors++;
      $display("FAIL ir: got ir=%h sel=%b want ir=%h sel=%b", ir_o, user_select_o, mir, sel);
    end
    if ({tck_o, tdi_o} !== {tck, td_i}) begin
      errors++;
      $display("FAIL feedthrough: got %b%b want %b%b", tck_o, tdi_o, tck, td_i);
    end
    checks++;
    @(negedge tck);
    #1;
    checks++;
    if ({td_o, tdo_oe_o} !== {(ms == 7) ? mirs[0] : (mir == 5'h1) ? midc[0] : (sel != 0) ? |(sel & user_tdo_i) : mbyp, ms == 6 || ms == 7}) begin
      errors++;
      $display("FAIL tdo: got td_o=%b oe=%b in state %0d ir=%h", td_o, tdo_oe_o, ms, mir);
    end
    seen = td_o;
  endtask

  // From RTI: enter Shift-IR/DR, shift n bits (td_i = din LSB first), update, return to RTI
  task automatic shift(input logic is_ir, input logic [63:0] din, input int n, output logic [63:0] dout);
    logic t;
    dout = '0;
    step(1, 0, t);
    if (is_ir) step(1, 0, t);
    step(0, 0, t);
    step(0, 0, t);
    dout[0] = t;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], t);
      if (i < n - 1) dout[i+1] = t;
    end
    step(1, 0, t);
    step(0, 0, t);
  endtask

  task automatic do_reset();
    trst_ni = 0;
    @(negedge tck);
    #1;
    model_reset();
    checks++;
    if ({td_o, tdo_oe_o, state_o, tlr_o, ir_o, user_select_o} !== {1'b0, 1'b0, 4'd0, 1'b1, 5'h1, 2'b00}) begin
      errors++;
      $display("FAIL reset: got td=%b oe=%b state=%0d tlr=%b ir=%h sel=%b", td_o, tdo_oe_o, state_o, tlr_o, ir_o, user_select_o);
    end
    trst_ni = 1;
  endtask

  task automatic test_reset();
    logic t;
    do_reset();
    step(1, 1, t);
    step(1, 0, t);
    step(0, 1, t);
  endtask

  task automatic test_idcode();
    logic [63:0] d;
    shift(0, 64'($urandom), 32, d);
    checks++;
    if (d[31:0] !== Idc) begin
      errors++;
      $display("FAIL idcode_stream: got %h want %h", d[31:0], Idc);
    end
  endtask

  task automatic test_user();
    logic [63:0] d;
    shift(1, 64'b10001, 5, d);
    checks++;
    if (d[4:0] !== 5'b00101) begin
      errors++;
      $display("FAIL ir_capture: got %b want %b", d[4:0], 5'b00101);
    end
    checks++;
    if ({ir_o, user_select_o} !== {5'h11, 2'b10}) begin
      errors++;
      $display("FAIL user1_select: got ir=%h sel=%b want ir=11 sel=10", ir_o, user_select_o);
    end
    shift(0, 64'($urandom), 8, d);
  endtask

  task automatic test_bypass();
    logic [63:0] d, din;
    shift(1, 64'h1f, 5, d);
    shift(0, 64'b01101, 5, d);
    checks++;
    if (d[4:0] !== 5'b11010) begin
      errors++;
      $display("FAIL bypass_1f: got %b want %b", d[4:0], 5'b11010);
    end
    shift(1, 64'h12, 5, d);
    checks++;
    if (user_select_o !== 2'b00) begin
      errors++;
      $display("FAIL sel_12: got %b want 00", user_select_o);
    end
    din = {$urandom, $urandom};
    shift(0, din, 16, d);
    checks++;
    if (d[15:0] !== {din[14:0], 1'b0}) begin
      errors++;
      $display("FAIL bypass_12: got %h want %h", d[15:0], {din[14:0], 1'b0});
    end
  endtask

  task automatic test_tlr_escape();
    logic [63:0] d;
    logic t;
    int upd = 0;
    shift(1, 64'h10, 5, d);
    step(1, 0, t);
    step(0, 0, t);
    step(0, 1, t);
    step(0, 0, t);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, t);
      upd += int'(update_o);
    end
    checks++;
    if ({upd, state_o, tlr_o, ir_o} !== {32'd1, 4'd0, 1'b1, 5'h1}) begin
      errors++;
      $display("FAIL tlr_escape: got upd=%0d state=%0d tlr=%b ir=%h want 1 0 1 01", upd, state_o, tlr_o, ir_o);
    end
    step(0, 0, t);
  endtask

  task automatic test_reset_mid_shift();
    logic [63:0] d;
    logic t;
    shift(1, 64'h11, 5, d);
    step(1, 0, t);
    step(1, 0, t);
    step(0, 0, t);
    step(0, 0, t);
    step(0, 1, t);
    step(0, 1, t);
    do_reset();
    step(0, 0, t);
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic t;
    for (int r = 0; r < 6; r++) begin
      shift(1, 64'($urandom_range(0, 31)), 5, d);
      shift(0, {$urandom, $urandom}, $urandom_range(1, 40), d);
    end
    for (int i = 0; i < 400; i++) step(1'($urandom), 1'($urandom), t);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idcode();
    test_user();
    test_bypass();
    test_tlr_escape();
    test_reset_mid_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtag_tap_multi.md
JTAG_TAP_MULTI -- requirements
Module: jtag_tap_multi

Interface
REQ-001 SHALL provide parameter IrLength, default 5, instruction register width (>=3).
REQ-002 SHALL provide parameter IdcodeValue, default 32'h00000001, IDCODE DR capture value (bit 0 = 1).
REQ-003 SHALL provide parameter NumUserDr, default 2, number of user DR channels (1..8).
REQ-004 SHALL provide parameter UserIrBase, default 'h10, IR opcode of user channel 0; channel k uses UserIrBase+k.
REQ-005 SHALL provide parameter IrCaptureValue, default 'b00101, value loaded in Capture-IR (two LSBs = 2'b01).
REQ-006 tck_i  in  1  JTAG test clock.
REQ-007 trst_ni  in  1  JTAG reset; asynchronous, active-low.
REQ-008 tms_i  in  1  test mode select, sampled on tck_i rising edge.
REQ-009 td_i  in  1  serial data in.
REQ-010 td_o  out  1  serial data out, changes on tck_i falling edge.
REQ-011 tdo_oe_o  out  1  td_o output enable.
REQ-012 tck_o / tdi_o  out  1 each  feed-through of tck_i / td_i.
REQ-013 capture_o / shift_o / update_o  out  1 each  TAP in Capture-DR / Shift-DR / Update-DR.
REQ-014 user_select_o  out  NumUserDr  one-hot user channel select (all zero when none).
REQ-015 user_tdo_i  in  NumUserDr  serial out of each user DR.
REQ-016 tlr_o  out  1  TAP in Test-Logic-Reset (synchronous clear for downstream DMI).
REQ-017 ir_o  out  IrLength  current latched instruction.
REQ-018 state_o  out  4  current TAP state encoding (debug).

Function
REQ-019 SHALL implement the 16-state IEEE 1149.1 TAP FSM clocked on tck_i rising edge; encoding 0..15: TLR, RTI, SelDR, SelIR, CapDR, CapIR, ShDR, ShIR, Ex1DR, Ex1IR, PauDR, PauIR, UpdDR, UpdIR, Ex2DR, Ex2IR.
REQ-020 Transitions: TLR tms?TLR:RTI; RTI tms?SelDR:RTI; SelDR tms?SelIR:CapDR; SelIR tms?TLR:CapIR; Cap/Sh tms?Ex1:Sh; Ex1 tms?Upd:Pau; Pau tms?Ex2:Pau; Ex2 tms?Upd:Sh; Upd tms?SelDR:RTI (IR and DR paths symmetric).
REQ-021 Five consecutive tms=1 edges SHALL reach TLR from any state.
REQ-022 In TLR the IR SHALL be loaded with IDCODE ('h1) on each rising edge.
REQ-023 CapIR: IR shift reg <= IrCaptureValue; ShIR: shift reg <= {td_i, shift[IrLength-1:1]} (LSB first); UpdIR: IR <= shift reg.
REQ-024 Decode: 'h1 -> IDCODE; UserIrBase+k (k<NumUserDr) -> user_select_o[k]=1; 'h0, all-ones, and every other value -> BYPASS.
REQ-025 IDCODE DR: CapDR loads IdcodeValue; ShDR shifts {td_i, idcode[31:1]}.
REQ-026 BYPASS DR: CapDR loads 0; ShDR loads td_i (1-cycle delay).
REQ-027 User DRs are external; block only provides select, capture_o/shift_o/update_o (not gated by select) and muxes user_tdo_i.
REQ-028 TDO mux: ShIR -> IR shift[0]; else IDCODE -> idcode[0]; user k -> user_tdo_i[k]; else bypass bit.
REQ-029 td_o and tdo_oe_o SHALL be registered on tck_i falling edge; tdo_oe_o = (ShIR|ShDR), so both lag state by half a tck.
REQ-030 capture_o, shift_o, update_o, tlr_o SHALL be combinational decodes of the current state.
REQ-031 IR changes only in UpdIR or TLR; exiting via Pause/Exit2 without Update SHALL leave IR unchanged.

Reset
REQ-032 trst_ni low SHALL asynchronously force: state TLR, IR IDCODE, IR shift reg 0, idcode reg IdcodeValue, bypass 0, td_o 0, tdo_oe_o 0.
REQ-033 After release, tlr_o=1 and user_select_o=0 until first tck_i edge with tms=0.
REQ-034 trst_ni assertion mid-shift SHALL abort shift with no IR/DR update.

Verification
REQ-035 Reset then tms=0, 1,0,0 (CapDR), 32 ShDR clocks -> td_o stream equals 32'h00000001 LSB first.
REQ-036 Load IR='h11 via ShIR (td_i 1,0,0,0,1) -> td_o during shift shows 1,0,1,0,0; after UpdIR user_select_o=2'b10, ir_o='h11.
REQ-037 IR='h1f, shift DR pattern 1,0,1,1 -> td_o shows 0 then same pattern delayed one tck.
REQ-038 IR='h12 (outside NumUserDr=2) -> user_select_o=0, BYPASS behaviour.
REQ-039 From ShDR with user 0 selected, tms=1 five clocks -> state_o=0, tlr_o=1, ir_o='h1, no update_o pulse beyond Ex1->Upd path.
REQ-040 Assert trst_ni low mid-ShIR -> immediate td_o=0, tdo_oe_o=0, state_o=0, ir_o='h1.
